// File: rtl/train_ctrl_pkg.sv
// Shared types and helpers for the perceptron training controller.
// Build option: TRAIN_PARALLEL_UPDATE_EN (single-cycle weight/bias update).
package train_ctrl_pkg;

  localparam int DEF_NUM_IN  = 2;
  localparam int DEF_CNT_W   = 32;
  localparam int DEF_EPOCH_W = 16;
  localparam int STATE_W     = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_INIT,
    S_FETCH,
    S_COMPUTE,
    S_UPDATE,
    S_EPOCH_END,
    S_DONE
  } state_t;

  // One-hot weight strobe decode: bit k is set when the update index is k.
  function automatic logic w_sel(
    input int unsigned idx,
    input int unsigned k
  );
    return idx == k;
  endfunction

endpackage

// File: rtl/train_sample_seq.sv
// Sample address counter for the training controller.
// Clear, increment and last-sample detect against the latched count.
module train_sample_seq #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] n,
  output logic [CNT_W-1:0] addr,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (inc) begin
      addr <= addr + 1'b1;
    end
  end

  assign last = (addr == n - 1'b1);

endmodule

// File: rtl/train_ctrl_seq.sv
// Perceptron training controller: fetch, compute, update, epoch/convergence.
// Build option: TRAIN_PARALLEL_UPDATE_EN (single-cycle weight/bias update).
module train_ctrl_seq
  import train_ctrl_pkg::*;
#(
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int EPOCH_W = DEF_EPOCH_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   n_samples,
  input  logic [EPOCH_W-1:0] max_epochs,
  input  logic               sample_valid,
  input  logic               eq_flag,
  output logic               sample_req,
  output logic [CNT_W-1:0]   sample_addr,
  output logic               ld_x,
  output logic               ld_t,
  output logic               ld_yin,
  output logic               init_w,
  output logic               init_b,
  output logic [NUM_IN-1:0]  ld_w,
  output logic               ld_b,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic               timeout,
  output logic [EPOCH_W-1:0] epoch_cnt
);

  state_t             state;
  state_t             nxt;
  logic [CNT_W-1:0]   n_lat;
  logic [EPOCH_W-1:0] max_lat;
  logic               clean;
  logic               last;
  logic               clr;
  logic               inc;
  logic               adv;
  logic               upd_last;
  logic               tmo_hit;
  logic [EPOCH_W-1:0] epoch_inc;
  logic [EPOCH_W-1:0] epoch_nx;

`ifndef TRAIN_PARALLEL_UPDATE_EN
  localparam int WI_W = $clog2(NUM_IN + 1);
  localparam logic [WI_W-1:0] W_LAST = WI_W'(NUM_IN);

  logic [WI_W-1:0] w_idx;
  logic [WI_W-1:0] w_idx_nx;

  assign upd_last = (w_idx == W_LAST);
  assign w_idx_nx = (state == S_UPDATE) ? w_idx + 1'b1 : '0;
`else
  assign upd_last = 1'b1;
`endif

  train_sample_seq #(
    .CNT_W(CNT_W)
  ) u_seq (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (inc),
    .n   (n_lat),
    .addr(sample_addr),
    .last(last)
  );

  // Saturate so an unlimited run never wraps back to zero.
  assign epoch_inc = epoch_cnt + 1'b1;
  assign epoch_nx  = (&epoch_cnt) ? epoch_cnt : epoch_inc;
  assign tmo_hit   = (max_lat != '0) && (epoch_inc == max_lat);

  assign ld_x = (state == S_FETCH) && sample_valid;
  assign ld_t = ld_x;

  always_comb begin
    nxt = state;
    clr = 1'b0;
    inc = 1'b0;
    adv = 1'b0;
    unique case (state)
      S_IDLE:      if (start) nxt = S_INIT;
      S_INIT: begin
        clr = 1'b1;
        nxt = (n_lat == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH:     if (sample_valid) nxt = S_COMPUTE;
      S_COMPUTE: begin
        if (!eq_flag) nxt = S_UPDATE;
        else          adv = 1'b1;
      end
      S_UPDATE:    adv = upd_last;
      S_EPOCH_END: begin
        if (clean || tmo_hit) begin
          nxt = S_DONE;
        end else begin
          clr = 1'b1;
          nxt = S_FETCH;
        end
      end
      S_DONE:      nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
    if (adv) begin
      if (last) begin
        nxt = S_EPOCH_END;
      end else begin
        inc = 1'b1;
        nxt = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      n_lat      <= '0;
      max_lat    <= '0;
      clean      <= 1'b1;
      epoch_cnt  <= '0;
      converged  <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sample_req <= 1'b0;
      ld_yin     <= 1'b0;
      init_w     <= 1'b0;
      init_b     <= 1'b0;
      ld_w       <= '0;
      ld_b       <= 1'b0;
`ifndef TRAIN_PARALLEL_UPDATE_EN
      w_idx      <= '0;
`endif
    end else begin
      state      <= nxt;
      busy       <= (nxt != S_IDLE);
      done       <= (nxt == S_DONE);
      sample_req <= (nxt == S_FETCH);
      ld_yin     <= (nxt == S_COMPUTE);
      init_w     <= (nxt == S_INIT);
      init_b     <= (nxt == S_INIT);
`ifndef TRAIN_PARALLEL_UPDATE_EN
      w_idx      <= w_idx_nx;
      for (int k = 0; k < NUM_IN; k++) begin
        ld_w[k] <= (nxt == S_UPDATE) &&
                   w_sel(int'(w_idx_nx), k);
      end
      ld_b       <= (nxt == S_UPDATE) && (w_idx_nx == W_LAST);
`else
      ld_w       <= {NUM_IN{nxt == S_UPDATE}};
      ld_b       <= (nxt == S_UPDATE);
`endif
      unique case (state)
        S_IDLE: begin
          if (start) begin
            n_lat     <= n_samples;
            max_lat   <= max_epochs;
            converged <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        S_INIT: begin
          epoch_cnt <= '0;
          clean     <= 1'b1;
          if (n_lat == '0) converged <= 1'b1;
        end
        S_COMPUTE: begin
          if (!eq_flag) clean <= 1'b0;
        end
        S_EPOCH_END: begin
          epoch_cnt <= epoch_nx;
          if (clean)        converged <= 1'b1;
          else if (tmo_hit) timeout   <= 1'b1;
          else              clean     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
